// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: stall/flush control for load-use, memory waits and
// taken-branch redirects, plus a saturating count of fetch-stall cycles.
module hazard_controller #(
    parameter int LOAD_USE_STALL_CYCLES = 1,
    parameter int BRANCH_PENALTY_CYCLES = 2,
    parameter int COUNTER_WIDTH         = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [4:0]               decode_register_number_a,
    input  logic                     decode_use_a,
    input  logic [4:0]               decode_register_number_b,
    input  logic                     decode_use_b,
    input  logic [4:0]               execute_destination_register_number,
    input  logic                     execute_write_enable,
    input  logic                     execute_is_load,
    input  logic                     execute_branch_taken,
    input  logic                     memory_access_request_valid,
    input  logic                     memory_access_request_ready,
    output logic                     stall_fetch,
    output logic                     stall_decode,
    output logic                     stall_execute,
    output logic                     stall_memory_access,
    output logic                     flush_decode,
    output logic                     flush_execute,
    output logic                     flush_write_back,
    output logic [1:0]               hazard_state,
    output logic [COUNTER_WIDTH-1:0] stall_cycle_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LOAD_USE = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    localparam logic [3:0] LU_RELOAD = 4'(LOAD_USE_STALL_CYCLES - 1);
    localparam logic [3:0] BR_RELOAD = 4'(BRANCH_PENALTY_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_wait;
    logic hit_a;
    logic hit_b;
    logic load_use;

    assign mem_wait = memory_access_request_valid & ~memory_access_request_ready;
    assign hit_a    = decode_use_a &
                      (decode_register_number_a == execute_destination_register_number);
    assign hit_b    = decode_use_b &
                      (decode_register_number_b == execute_destination_register_number);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = execute_is_load & execute_write_enable &
                      (execute_destination_register_number != 5'd0) & (hit_a | hit_b);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mem_wait) begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end else if (execute_branch_taken) begin
            if (BRANCH_PENALTY_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = BR_RELOAD;
            end else begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        end else begin
            case (state_q)
                ST_FLUSH, ST_LOAD_USE: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    if (load_use && (LOAD_USE_STALL_CYCLES > 1)) begin
                        state_d = ST_LOAD_USE;
                        cnt_d   = LU_RELOAD;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_fetch         = 1'b0;
        stall_decode        = 1'b0;
        stall_execute       = 1'b0;
        stall_memory_access = 1'b0;
        flush_decode        = 1'b0;
        flush_execute       = 1'b0;
        flush_write_back    = 1'b0;
        if (!reset_n) begin
            stall_fetch = 1'b0;
        end else if (mem_wait) begin
            stall_fetch         = 1'b1;
            stall_decode        = 1'b1;
            stall_execute       = 1'b1;
            stall_memory_access = 1'b1;
            flush_write_back    = 1'b1;
        end else if (execute_branch_taken) begin
            flush_decode  = 1'b1;
            flush_execute = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            flush_decode = 1'b1;
        end else if ((state_q == ST_LOAD_USE) || load_use) begin
            // The first bubble is issued from RUN in the detection cycle itself.
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            flush_execute = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_fetch && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + COUNTER_WIDTH'(1);
        end
    end

    assign hazard_state      = state_q;
    assign stall_cycle_count = stall_cnt_q;

endmodule
